ppu_fb_writer: RTL and testbench
================================

PPU_FB_WRITER -- requirements
Module: ppu_fb_writer

Interface
REQ-001 FIFO_DEPTH, 8, pixel buffer depth in entries; power of two, 2..32.
REQ-002 LCD_W, 160, visible pixels per line.
REQ-003 LCD_H, 144, visible lines per frame.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 LCD_EN  input  1  LCDC bit 7; low holds the block idle.
REQ-007 PPU_MODE  input  2  PPU mode: 00 H_BLANK, 01 V_BLANK, 10 SCAN, 11 DRAW.
REQ-008 PX_OUT  input  2  raw background colour index from the PPU pixel shifter.
REQ-009 PX_valid  input  1  PX_OUT carries a pixel this cycle.
REQ-010 BGP  input  8  background palette register (FF47).
REQ-011 FB_READY  input  1  framebuffer accepts a write this cycle.
REQ-012 FB_WE  output  1  write request; FB_ADDR/FB_DATA valid while high.
REQ-013 FB_ADDR  output  15  linear pixel address, y*LCD_W+x.
REQ-014 FB_DATA  output  2  palette-mapped shade.
REQ-015 FRAME_DONE  output  1  one-cycle pulse at end of last visible line.
REQ-016 OVERFLOW  output  1  sticky flag: pixel dropped because FIFO was full.

Function
REQ-017 Shade: FB_DATA entry = BGP[2*PX_OUT+1 : 2*PX_OUT], BGP sampled in the same cycle as PX_valid.
REQ-018 Counters: x_cnt 0..LCD_W-1 and y_cnt 0..LCD_H-1; entry address = y_cnt*LCD_W + x_cnt, computed on push, 15-bit, no truncation for 160x144 (max 23039).
REQ-019 Accepted pixel (PX_valid=1, LCD_EN=1, PPU_MODE=DRAW, x_cnt<LCD_W): push {address, shade}, x_cnt+1.
REQ-020 PX_valid with x_cnt==LCD_W (line already full): pixel discarded, no push, x_cnt unchanged, OVERFLOW unaffected.
REQ-021 PX_valid outside DRAW mode: ignored.
REQ-022 Line advance on DRAW->non-DRAW transition of PPU_MODE (previous-cycle mode register): x_cnt<=0; y_cnt<=y_cnt+1, or 0 with FRAME_DONE=1 next cycle when y_cnt==LCD_H-1.
REQ-023 Short line (fewer than LCD_W pixels before DRAW exit): remaining pixels not written; line still advances.
REQ-024 Pixel accepted in the same cycle as a line advance is impossible by REQ-021; the advance uses only the mode edge.
REQ-025 FIFO: show-ahead; FB_WE = not empty; FB_ADDR/FB_DATA = head entry, driven from registers.
REQ-026 Pop when FB_WE && FB_READY.
REQ-027 Latency: pixel pushed into an empty FIFO at edge N appears on FB_WE after edge N, i.e. one cycle.
REQ-028 Full FIFO with push: accepted only if a pop occurs the same cycle; otherwise pixel dropped, x_cnt still increments, OVERFLOW<=1.
REQ-029 Simultaneous push and pop when not full: count unchanged, order preserved.
REQ-030 Pointers wrap modulo FIFO_DEPTH; count register is log2(FIFO_DEPTH)+1 bits.
REQ-031 LCD_EN low: x_cnt, y_cnt and previous-mode register cleared to 0 (synchronous clear); no pushes; FIFO continues draining to the framebuffer.
REQ-032 LCD_EN rising: the next DRAW line is line 0.
REQ-033 FRAME_DONE never asserts for more than one consecutive cycle.

Reset
REQ-034 During rst: FB_WE=0, FB_ADDR=0, FB_DATA=0, FRAME_DONE=0, OVERFLOW=0, FIFO empty, x_cnt=y_cnt=0, previous mode=H_BLANK.
REQ-035 Reset mid-frame or mid-write discards all buffered entries; the first DRAW line after release is line 0.
REQ-036 OVERFLOW clears only by rst.

Verification
REQ-037 BGP=0xE4, FB_READY=1, one DRAW line of 160 pixels with PX_OUT=i%4 -> 160 writes, addr 0..159, data=i%4, each one cycle after input.
REQ-038 BGP=0x1B, PX_OUT=3 -> FB_DATA=0; PX_OUT=0 -> FB_DATA=3.
REQ-039 144 full lines -> FRAME_DONE single pulse after line 143 DRAW exit; next pixel addr 0; last addr in frame 23039.
REQ-040 FB_READY=0, 8 pixels pushed -> FIFO full, no OVERFLOW; 9th pixel -> OVERFLOW=1; FB_READY=1 -> exactly 8 writes, addr 0..7; next accepted pixel addr 9.
REQ-041 161 pixels in one DRAW period -> 160 writes, 161st dropped, OVERFLOW=0; next line starts at addr 160.
REQ-042 rst pulsed during line 5 with 3 entries buffered -> FB_WE=0 immediately; next DRAW line writes from addr 0.

Source files
------------

// File: rtl/ppu_fb_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : ppu_fb_writer_if
// Purpose  : Bundles the PPU pixel-side inputs and the framebuffer write-side
//            signals of ppu_fb_writer.
//            master : the framebuffer writer (consumes pixels, drives writes)
//            slave  : the surrounding PPU / framebuffer environment
// Signals  : LCD_EN, PPU_MODE[1:0], PX_OUT[1:0], PX_valid, BGP[7:0], FB_READY
//            FB_WE, FB_ADDR[14:0], FB_DATA[1:0], FRAME_DONE, OVERFLOW
// Revision : 1.0 - initial release
// ============================================================================
interface ppu_fb_writer_if;
    logic        LCD_EN;
    logic [1:0]  PPU_MODE;
    logic [1:0]  PX_OUT;
    logic        PX_valid;
    logic [7:0]  BGP;
    logic        FB_READY;
    logic        FB_WE;
    logic [14:0] FB_ADDR;
    logic [1:0]  FB_DATA;
    logic        FRAME_DONE;
    logic        OVERFLOW;

    modport master (
        input  LCD_EN, PPU_MODE, PX_OUT, PX_valid, BGP, FB_READY,
        output FB_WE, FB_ADDR, FB_DATA, FRAME_DONE, OVERFLOW
    );

    modport slave (
        output LCD_EN, PPU_MODE, PX_OUT, PX_valid, BGP, FB_READY,
        input  FB_WE, FB_ADDR, FB_DATA, FRAME_DONE, OVERFLOW
    );
endinterface
`default_nettype wire

// File: rtl/ppu_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : ppu_fb_writer
// Purpose  : Captures background pixels from the PPU shifter during DRAW mode,
//            maps them through the BGP palette, tags each with its linear
//            framebuffer address (y*LCD_W+x) and buffers them in a show-ahead
//            FIFO that drains to the framebuffer write port.
// Ports    : clk, rst (async, active-high)
//            bus (ppu_fb_writer_if.master):
//              in : LCD_EN, PPU_MODE, PX_OUT, PX_valid, BGP, FB_READY
//              out: FB_WE, FB_ADDR, FB_DATA, FRAME_DONE, OVERFLOW
// Revision : 1.0 - initial release
// ============================================================================
module ppu_fb_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int LCD_W      = 160,
    parameter int LCD_H      = 144
) (
    input  wire logic       clk,
    input  wire logic       rst,
    ppu_fb_writer_if.master bus
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_x_w   = $clog2(LCD_W + 1);   // x must be able to hold LCD_W ("line full")
    localparam int c_y_w   = $clog2(LCD_H);
    localparam int c_ent_w = 17;                   // {addr[14:0], shade[1:0]}

    localparam logic [1:0]       c_mode_hblank = 2'b00;
    localparam logic [1:0]       c_mode_draw   = 2'b11;
    localparam logic [c_ptr_w:0] c_depth       = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_x_w-1:0] c_lcd_w       = c_x_w'(LCD_W);
    localparam logic [c_y_w-1:0] c_last_y      = c_y_w'(LCD_H - 1);

    logic [c_x_w-1:0]   r_x;
    logic [c_y_w-1:0]   r_y;
    logic [1:0]         r_prev_mode;
    logic               r_frame_done;
    logic               r_overflow;
    logic [c_ent_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic        w_draw;
    logic        w_line_adv;
    logic        w_take;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic [1:0]  w_shade;
    logic [14:0] w_addr;

    assign w_draw     = (bus.PPU_MODE == c_mode_draw);
    // Line advance is driven purely by the DRAW -> non-DRAW edge of the mode.
    assign w_line_adv = bus.LCD_EN && (r_prev_mode == c_mode_draw) && !w_draw;
    // A pixel is "taken" (x advances) even if the FIFO later has to drop it.
    assign w_take     = bus.LCD_EN && w_draw && bus.PX_valid && (r_x < c_lcd_w);
    assign w_full     = (r_count == c_depth);
    assign w_pop      = (r_count != '0) && bus.FB_READY;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push     = w_take && (!w_full || w_pop);
    assign w_shade    = bus.BGP[{bus.PX_OUT, 1'b0} +: 2];
    assign w_addr     = 15'(32'(r_y) * LCD_W + 32'(r_x));

    // Pixel position tracking and end-of-frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_prev_mode  <= c_mode_hblank;
            r_frame_done <= 1'b0;
        end else if (!bus.LCD_EN) begin
            r_x          <= '0;
            r_y          <= '0;
            r_prev_mode  <= c_mode_hblank;
            r_frame_done <= 1'b0;
        end else begin
            r_prev_mode  <= bus.PPU_MODE;
            r_frame_done <= 1'b0;
            if (w_line_adv) begin
                r_x <= '0;
                if (r_y == c_last_y) begin
                    r_y          <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_y <= r_y + c_y_w'(1);
                end
            end else if (w_take) begin
                r_x <= r_x + c_x_w'(1);
            end
        end
    end

    // Sticky overflow: a taken pixel found the FIFO full with no pop to make room
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_take && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    // Show-ahead FIFO; storage is reset so the head reads zero out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_addr, w_shade};
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.FB_WE                  = (r_count != '0);
    assign {bus.FB_ADDR, bus.FB_DATA} = r_mem[r_rd_ptr];
    assign bus.FRAME_DONE             = r_frame_done;
    assign bus.OVERFLOW               = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ppu_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_fb_writer
// Purpose  : Self-checking bench for ppu_fb_writer. A frame-level reference
//            model predicts buffered writes into a scoreboard queue; a monitor
//            pops and compares on every framebuffer write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_fb_writer;
    localparam int DEPTH = 8;
    localparam int W     = 160;
    localparam int H     = 144;

    typedef struct {
        int addr;
        int data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ppu_fb_writer_if bus();

    ppu_fb_writer #(
        .FIFO_DEPTH (DEPTH),
        .LCD_W      (W),
        .LCD_H      (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t exp_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_writes  = 0;
    int   n_fd      = 0;
    int   max_addr  = -1;
    int   last_addr = -1;

    // reference model state: pixel position, buffered-entry count, flags
    int mx    = 0;
    int my    = 0;
    int mprev = 0;
    int m_occ = 0;
    bit m_ovf = 1'b0;
    bit m_fd  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: predicts the effect of the coming rising edge from the
    // inputs held stable at the falling edge.
    always @(negedge clk) begin : model
        int  mode;
        int  sh;
        bit  pop;
        if (rst) begin
            exp_q.delete();
            mx = 0; my = 0; mprev = 0; m_occ = 0; m_ovf = 1'b0; m_fd = 1'b0;
        end else begin
            chk("fb_we", bus.FB_WE, (m_occ != 0));
            chk("frame_done", bus.FRAME_DONE, m_fd);
            chk("overflow", bus.OVERFLOW, m_ovf);
            if (bus.FRAME_DONE === 1'b1) n_fd++;
            mode = int'(bus.PPU_MODE);
            pop  = (m_occ != 0) && bus.FB_READY;
            m_fd = 1'b0;
            if (!bus.LCD_EN) begin
                mx = 0; my = 0; mprev = 0;
            end else begin
                if (mode == 3 && bus.PX_valid && mx < W) begin
                    if (m_occ < DEPTH || pop) begin
                        sh = (int'(bus.BGP) >> (2 * int'(bus.PX_OUT))) & 3;
                        exp_q.push_back('{my * W + mx, sh});
                        m_occ++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                    mx++;
                end
                if (mprev == 3 && mode != 3) begin
                    mx = 0;
                    if (my == H - 1) begin
                        my   = 0;
                        m_fd = 1'b1;
                    end else begin
                        my++;
                    end
                end
                mprev = mode;
            end
            if (pop) m_occ--;
        end
    end

    // Monitor: every accepted framebuffer write is matched to the scoreboard head
    always @(negedge clk) begin : monitor
        ent_t e;
        if (!rst && bus.FB_WE === 1'b1 && bus.FB_READY === 1'b1) begin
            n_writes++;
            last_addr = int'(bus.FB_ADDR);
            if (last_addr > max_addr) max_addr = last_addr;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL fb_write_unexpected actual_addr=%0d actual_data=%0d required=no write",
                         bus.FB_ADDR, bus.FB_DATA);
            end else begin
                e = exp_q.pop_front();
                chk("fb_addr", bus.FB_ADDR, e.addr);
                chk("fb_data", bus.FB_DATA, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.PX_valid = 1'b0;
        bus.PPU_MODE = 2'b00;
        repeat (n) tick();
    endtask

    // pat: 0 random pixel+palette, 1 i%4, 2 alternating 3/0
    // rdy: 0 FB_READY low, 1 high, 2 random (mostly high)
    task automatic do_line(input int npx, input int pat, input int rdy, input bit bub);
        int i;
        i = 0;
        bus.PX_valid = 1'b0;
        bus.PPU_MODE = 2'b10;
        tick();
        bus.PPU_MODE = 2'b11;
        while (i < npx) begin
            bus.PX_valid = bub ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (pat == 1)      bus.PX_OUT = 2'(i % 4);
            else if (pat == 2) bus.PX_OUT = (i % 2 == 0) ? 2'd3 : 2'd0;
            else begin
                bus.PX_OUT = 2'($urandom);
                bus.BGP    = 8'($urandom);
            end
            if (rdy == 2) bus.FB_READY = ($urandom_range(0, 9) != 0);
            else          bus.FB_READY = rdy[0];
            if (bus.PX_valid) i++;
            tick();
        end
        bus.PX_valid = 1'b0;
        tick();
        bus.PPU_MODE = 2'b00;
        bus.FB_READY = 1'b1;
        tick();
    endtask

    task automatic pulse_rst();
        bus.PX_valid = 1'b0;
        bus.PPU_MODE = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #5000000;
        n_errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : stim
        int w0;
        bus.LCD_EN   = 1'b1;
        bus.PPU_MODE = 2'b00;
        bus.PX_OUT   = 2'd0;
        bus.PX_valid = 1'b0;
        bus.BGP      = 8'hE4;
        bus.FB_READY = 1'b1;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fb_we", bus.FB_WE, 0);
        chk("rst_fb_addr", bus.FB_ADDR, 0);
        chk("rst_fb_data", bus.FB_DATA, 0);
        chk("rst_frame_done", bus.FRAME_DONE, 0);
        chk("rst_overflow", bus.OVERFLOW, 0);
        rst = 1'b0;
        tick();

        // identity palette, one full line of i%4
        bus.BGP = 8'hE4;
        do_line(W, 1, 1, 1'b0);
        idle(4);
        chk("line0_writes", n_writes, W);
        chk("line0_last_addr", last_addr, W - 1);

        // inverting palette
        bus.BGP = 8'h1B;
        do_line(8, 2, 1, 1'b0);
        idle(4);

        // one pixel too many in a line: dropped silently
        do_line(W + 1, 0, 1, 1'b0);
        idle(4);
        chk("ovf_after_161", bus.OVERFLOW, 0);

        // rest of the frame: random lengths, bubbles and back-pressure
        for (int l = 3; l < H - 1; l++) begin
            do_line($urandom_range(0, W + 10), 0, 2, 1'b1);
            idle($urandom_range(2, 8));
        end
        idle(12);
        do_line(W, 0, 1, 1'b1);
        idle(6);
        chk("frame_done_pulses", n_fd, 1);
        chk("frame_max_addr", max_addr, W * H - 1);
        do_line(1, 0, 1, 1'b0);
        idle(3);
        chk("addr_after_frame", last_addr, 0);

        // LCD disable: buffered entries still drain, position restarts at line 0
        do_line(20, 0, 0, 1'b0);
        bus.LCD_EN   = 1'b0;
        bus.FB_READY = 1'b1;
        bus.PPU_MODE = 2'b11;
        bus.PX_valid = 1'b1;
        repeat (12) tick();
        chk("drain_while_disabled", exp_q.size(), 0);
        bus.PX_valid = 1'b0;
        bus.PPU_MODE = 2'b00;
        bus.LCD_EN   = 1'b1;
        tick();
        do_line(2, 1, 1, 1'b0);
        idle(3);
        chk("addr_after_enable", last_addr, 1);

        // full FIFO behaviour
        pulse_rst();
        chk("ovf_cleared_by_rst", bus.OVERFLOW, 0);
        bus.FB_READY = 1'b0;
        bus.PPU_MODE = 2'b11;
        for (int k = 0; k < DEPTH; k++) begin
            bus.PX_valid = 1'b1;
            bus.PX_OUT   = 2'(k % 4);
            tick();
        end
        bus.PX_OUT = 2'd1;
        @(negedge clk);
        chk("ovf_full_no_drop", bus.OVERFLOW, 0);
        chk("fb_we_full", bus.FB_WE, 1);
        tick();
        bus.PX_valid = 1'b0;
        @(negedge clk);
        chk("ovf_after_drop", bus.OVERFLOW, 1);
        tick();
        w0 = n_writes;
        bus.FB_READY = 1'b1;
        repeat (12) tick();
        chk("drain_writes", n_writes - w0, DEPTH);
        chk("drain_last_addr", last_addr, DEPTH - 1);
        bus.PX_valid = 1'b1;
        bus.PX_OUT   = 2'd2;
        tick();
        bus.PX_valid = 1'b0;
        repeat (3) tick();
        chk("addr_after_drop", last_addr, DEPTH + 1);
        idle(3);

        // reset in the middle of line 5 with entries buffered
        pulse_rst();
        for (int l = 0; l < 5; l++) begin
            do_line(2, 0, 1, 1'b0);
            idle(3);
        end
        bus.PPU_MODE = 2'b10;
        tick();
        bus.PPU_MODE = 2'b11;
        bus.FB_READY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.PX_valid = 1'b1;
            bus.PX_OUT   = 2'($urandom);
            tick();
        end
        bus.PX_valid = 1'b0;
        tick();
        chk("fb_we_buffered", bus.FB_WE, 1);
        chk("buffered_head_addr", bus.FB_ADDR, 5 * W);
        bus.PPU_MODE = 2'b00;
        bus.FB_READY = 1'b1;
        rst = 1'b1;
        #1;
        chk("fb_we_async_rst", bus.FB_WE, 0);
        chk("fb_addr_async_rst", bus.FB_ADDR, 0);
        tick();
        rst = 1'b0;
        tick();
        do_line(4, 1, 1, 1'b0);
        idle(5);
        chk("addr_after_rst", last_addr, 3);

        idle(20);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
